// File: rtl/rv_instr_field_split_pkg.sv
// rtl/rv_instr_field_split_pkg.sv - RV32I widths and instruction field bit positions
package rv_instr_field_split_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int IMM12_W   = 12;
  localparam int IMM20_W   = 20;

  // Field positions are shared with the decoder so both agree on slicing.
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;
  localparam int IMM20_LSB  = 12;
  localparam int IMM20_MSB  = 31;
  localparam int IMM12_LSB  = 20;
  localparam int IMM12_MSB  = 31;

  localparam int OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int FUNCT3_W = FUNCT3_MSB - FUNCT3_LSB + 1;
  localparam int FUNCT7_W = FUNCT7_MSB - FUNCT7_LSB + 1;

endpackage

// File: rtl/rv_instr_field_split_sign_extend_12_32.sv
// rtl/rv_instr_field_split_sign_extend_12_32.sv - combinational 12-to-32 bit sign extension
module sign_extend_12_32
  import rv_instr_field_split_pkg::*;
(
  input  logic [IMM12_W-1:0] imm_i,
  output logic [XLEN-1:0]    imm_o
);

  assign imm_o = {{(XLEN-IMM12_W){imm_i[IMM12_W-1]}}, imm_i};

endmodule

// File: rtl/rv_instr_field_split.sv
// rtl/rv_instr_field_split.sv - registered RV32I instruction field splitter
module rv_instr_field_split
  import rv_instr_field_split_pkg::*;
(
  input  logic                 iwClk,
  input  logic                 iwRst,
  input  logic                 iwValid,
  input  logic [XLEN-1:0]      iwInstr,
  output logic                 owValid,
  output logic [REG_IDX_W-1:0] owRs1,
  output logic [REG_IDX_W-1:0] owRs2,
  output logic [REG_IDX_W-1:0] owRd,
  output logic [OPCODE_W-1:0]  owOpCode,
  output logic [FUNCT3_W-1:0]  owFunct3,
  output logic [FUNCT7_W-1:0]  owFunct7,
  output logic [IMM20_W-1:0]   owImmediate20,
  output logic [IMM12_W-1:0]   owImmediate12,
  output logic [IMM12_W-1:0]   owImmediate12SClass,
  output logic [XLEN-1:0]      owImmediate12Extended,
  output logic [XLEN-1:0]      owImmediate12SClassExtended
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;

  // An idle cycle drops valid but keeps the last word so fields stay stable.
  always_comb begin
    instr_d = instr_q;
    valid_d = iwValid;
    if (iwValid) begin
      instr_d = iwInstr;
    end
  end

  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign owValid             = valid_q;
  assign owOpCode            = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign owRd                = instr_q[RD_MSB:RD_LSB];
  assign owFunct3            = instr_q[FUNCT3_MSB:FUNCT3_LSB];
  assign owRs1               = instr_q[RS1_MSB:RS1_LSB];
  assign owRs2               = instr_q[RS2_MSB:RS2_LSB];
  assign owFunct7            = instr_q[FUNCT7_MSB:FUNCT7_LSB];
  assign owImmediate20       = instr_q[IMM20_MSB:IMM20_LSB];
  assign owImmediate12       = instr_q[IMM12_MSB:IMM12_LSB];
  assign owImmediate12SClass = {instr_q[FUNCT7_MSB:FUNCT7_LSB], instr_q[RD_MSB:RD_LSB]};

  sign_extend_12_32 u_sext_i_class (
    .imm_i (owImmediate12),
    .imm_o (owImmediate12Extended)
  );

  sign_extend_12_32 u_sext_s_class (
    .imm_i (owImmediate12SClass),
    .imm_o (owImmediate12SClassExtended)
  );

endmodule

// File: tb/tb_rv_instr_field_split.sv
// tb/tb_rv_instr_field_split.sv - directed-vector bench for rv_instr_field_split
module tb_rv_instr_field_split;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [31:0] instr_in;
  logic        valid_out;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [19:0] imm20;
  logic [11:0] imm12, imm12s;
  logic [31:0] imm12_ext, imm12s_ext;

  int n_vec;
  int n_err;

  rv_instr_field_split dut (
    .iwClk                       (clk),
    .iwRst                       (rst),
    .iwValid                     (valid_in),
    .iwInstr                     (instr_in),
    .owValid                     (valid_out),
    .owRs1                       (rs1),
    .owRs2                       (rs2),
    .owRd                        (rd),
    .owOpCode                    (opcode),
    .owFunct3                    (funct3),
    .owFunct7                    (funct7),
    .owImmediate20               (imm20),
    .owImmediate12               (imm12),
    .owImmediate12SClass         (imm12s),
    .owImmediate12Extended       (imm12_ext),
    .owImmediate12SClassExtended (imm12s_ext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive inputs mid-cycle, then sample 1 time unit after the next rising edge.
  task automatic step(input logic r, input logic v, input logic [31:0] w);
    @(negedge clk);
    rst      = r;
    valid_in = v;
    instr_in = w;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"},  {31'd0, valid_out}, 32'd0);
    check({tag, ".rs1"},    {27'd0, rs1},       32'd0);
    check({tag, ".rs2"},    {27'd0, rs2},       32'd0);
    check({tag, ".rd"},     {27'd0, rd},        32'd0);
    check({tag, ".opcode"}, {25'd0, opcode},    32'd0);
    check({tag, ".funct3"}, {29'd0, funct3},    32'd0);
    check({tag, ".funct7"}, {25'd0, funct7},    32'd0);
    check({tag, ".imm20"},  {12'd0, imm20},     32'd0);
    check({tag, ".imm12"},  {20'd0, imm12},     32'd0);
    check({tag, ".imm12s"}, {20'd0, imm12s},    32'd0);
    check({tag, ".ext"},    imm12_ext,          32'd0);
    check({tag, ".sext"},   imm12s_ext,         32'd0);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    valid_in = 1'b1;
    instr_in = 32'hFFFF_FFFF;

    // Reset wins over a valid all-ones word.
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    check_zero("rst1");
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    check_zero("rst2");

    // addi x1,x2,-1
    step(1'b0, 1'b1, 32'hFFF1_0093);
    check("addi.valid",  {31'd0, valid_out}, 32'd1);
    check("addi.opcode", {25'd0, opcode},    32'h13);
    check("addi.rd",     {27'd0, rd},        32'd1);
    check("addi.rs1",    {27'd0, rs1},       32'd2);
    check("addi.rs2",    {27'd0, rs2},       32'd31);
    check("addi.funct3", {29'd0, funct3},    32'd0);
    check("addi.funct7", {25'd0, funct7},    32'h7F);
    check("addi.imm20",  {12'd0, imm20},     32'hFFF10);
    check("addi.imm12",  {20'd0, imm12},     32'hFFF);
    check("addi.ext",    imm12_ext,          32'hFFFF_FFFF);
    check("addi.imm12s", {20'd0, imm12s},    32'hFE1);
    check("addi.sext",   imm12s_ext,         32'hFFFF_FFE1);

    // sw x5,8(x6)
    step(1'b0, 1'b1, 32'h0053_2423);
    check("sw.opcode", {25'd0, opcode},  32'h23);
    check("sw.rs1",    {27'd0, rs1},     32'd6);
    check("sw.rs2",    {27'd0, rs2},     32'd5);
    check("sw.funct3", {29'd0, funct3},  32'd2);
    check("sw.imm12s", {20'd0, imm12s},  32'h008);
    check("sw.sext",   imm12s_ext,       32'h0000_0008);
    check("sw.imm12",  {20'd0, imm12},   32'h005);
    check("sw.ext",    imm12_ext,        32'h0000_0005);

    // lui x10,0x12345
    step(1'b0, 1'b1, 32'h1234_5537);
    check("lui.opcode", {25'd0, opcode}, 32'h37);
    check("lui.rd",     {27'd0, rd},     32'd10);
    check("lui.imm20",  {12'd0, imm20},  32'h12345);

    // sub x3,x4,x5
    step(1'b0, 1'b1, 32'h4052_01B3);
    check("sub.opcode", {25'd0, opcode}, 32'h33);
    check("sub.funct7", {25'd0, funct7}, 32'h20);
    check("sub.rs2",    {27'd0, rs2},    32'd5);
    check("sub.rs1",    {27'd0, rs1},    32'd4);
    check("sub.rd",     {27'd0, rd},     32'd3);
    check("sub.imm12s", {20'd0, imm12s}, 32'h403);

    // Sign-extension boundaries for both immediate classes.
    step(1'b0, 1'b1, 32'h7FF0_0000);
    check("bnd7ff.imm12", {20'd0, imm12}, 32'h7FF);
    check("bnd7ff.ext",   imm12_ext,      32'h0000_07FF);
    check("bnd7ff.sext",  imm12s_ext,     32'h0000_07E0);
    step(1'b0, 1'b1, 32'h8000_0000);
    check("bnd800.ext",   imm12_ext,      32'hFFFF_F800);
    check("bnd800.sext",  imm12s_ext,     32'hFFFF_F800);
    step(1'b0, 1'b1, 32'h7E00_0F80);
    check("sbnd7ff.imm12s", {20'd0, imm12s}, 32'h7FF);
    check("sbnd7ff.sext",   imm12s_ext,      32'h0000_07FF);
    check("sbnd7ff.ext",    imm12_ext,       32'h0000_07E0);
    step(1'b0, 1'b1, 32'h8000_007F);
    check("sbnd800.imm12s", {20'd0, imm12s}, 32'h800);
    check("sbnd800.sext",   imm12s_ext,      32'hFFFF_F800);

    // Hold: idle cycles with a changing bus keep the captured word.
    step(1'b0, 1'b1, 32'hFFF1_0093);
    check("load.valid", {31'd0, valid_out}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0053_2423 + i * 32'h0101_0101);
      check($sformatf("hold%0d.valid", i),  {31'd0, valid_out}, 32'd0);
      check($sformatf("hold%0d.opcode", i), {25'd0, opcode},    32'h13);
      check($sformatf("hold%0d.rd", i),     {27'd0, rd},        32'd1);
      check($sformatf("hold%0d.rs1", i),    {27'd0, rs1},       32'd2);
      check($sformatf("hold%0d.ext", i),    imm12_ext,          32'hFFFF_FFFF);
    end

    // Reset mid-stream discards the held word even with valid asserted.
    step(1'b1, 1'b1, 32'h1234_5537);
    check_zero("rstmid");
    step(1'b0, 1'b0, 32'h1234_5537);
    check_zero("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
